// File: rtl/imem_responder_pkg.sv
// Shared constants and loader state type for the instruction memory responder.
package imem_responder_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } imem_ld_state_t;

endpackage

// File: rtl/imem_responder_word_assembler.sv
// Packs loader bytes little-endian into 32-bit words for the instruction RAM.
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done,
    output logic [1:0]  o_pending
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    // Outside an accept this is the zero-padded partial word used by a flush.
    assign o_word      = i_accept ? {i_byte, r_shift} : {8'h00, r_shift};
    assign o_word_done = i_accept && (r_idx == 2'd3);
    assign o_pending   = i_accept ? r_idx + 2'd1 : r_idx;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_accept) begin
            if (r_idx == 2'd3) begin
                r_idx   <= 2'd0;
                r_shift <= 24'd0;
            end else begin
                r_shift[{r_idx, 3'b000} +: 8] <= i_byte;
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction RAM with single-cycle fetch port and a byte-stream program loader.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic [31:0]                   imem_addr,
    input  logic                          imem_rd_en,
    output logic [31:0]                   imem_rdata_o,
    output logic                          imem_rvalid_o,
    output logic                          imem_fault_o,
    output logic                          imem_busy_o,
    input  logic                          ld_start_i,
    input  logic                          ld_valid_i,
    input  logic [7:0]                    ld_byte_i,
    input  logic                          ld_done_i,
    output logic                          ld_ready_o,
    output logic [$clog2(DEPTH_WORDS):0]  ld_count_o,
    output logic                          ld_overflow_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = AW + 1;

    imem_ld_state_t r_state;
    imem_ld_state_t w_next;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_fault;
    logic [AW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_busy;
    logic          w_ready;
    logic          w_bad;
    logic          w_clear;
    logic          w_accept;
    logic          w_wr;
    logic [31:0]   w_asm_word;
    logic          w_word_done;
    logic [1:0]    w_pending;

    assign w_bad = (imem_addr[1:0] != 2'b00)
                || ((imem_addr >> (AW + 2)) != 32'd0);

    assign w_accept = (r_state == LOAD) && ld_valid_i && !ld_start_i;
    assign w_clear  = ld_start_i || (r_state == FLUSH);
    assign w_wr     = w_word_done || (r_state == FLUSH);

    imem_word_assembler u_asm (
        .clk         (clk),
        .rst_i       (rst_i),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte      (ld_byte_i),
        .o_word      (w_asm_word),
        .o_word_done (w_word_done),
        .o_pending   (w_pending)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ld_start_i) w_next = LOAD;
            end
            LOAD: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
                if (ld_start_i)
                    w_next = LOAD;
                else if (ld_done_i)
                    w_next = (w_pending != 2'd0) ? FLUSH : IDLE;
            end
            FLUSH: begin
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A load request in the same cycle as a fetch drops the fetch.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rdata  <= NOP_INSTR;
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
        end else if (r_state != IDLE || ld_start_i) begin
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
        end else if (imem_rd_en) begin
            r_rvalid <= 1'b1;
            r_fault  <= w_bad;
            r_rdata  <= w_bad ? NOP_INSTR : r_mem[imem_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_ptr] <= w_asm_word;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (ld_start_i && r_state != FLUSH) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_wr) begin
            r_ptr <= r_ptr + AW'(1);
            if (r_ptr == AW'(DEPTH_WORDS - 1)) r_overflow <= 1'b1;
            if (r_count != CW'(DEPTH_WORDS)) r_count <= r_count + CW'(1);
        end
    end

    assign imem_rdata_o  = r_rdata;
    assign imem_rvalid_o = r_rvalid;
    assign imem_fault_o  = r_fault;
    assign imem_busy_o   = w_busy;
    assign ld_ready_o    = w_ready;
    assign ld_count_o    = r_count;
    assign ld_overflow_o = r_overflow;

endmodule

// File: tb/tb_imem_responder.sv
// Directed and randomized checks of imem_responder against a word-level model.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [31:0]   imem_addr;
    logic          imem_rd_en;
    logic [31:0]   imem_rdata_o;
    logic          imem_rvalid_o;
    logic          imem_fault_o;
    logic          imem_busy_o;
    logic          ld_start_i;
    logic          ld_valid_i;
    logic [7:0]    ld_byte_i;
    logic          ld_done_i;
    logic          ld_ready_o;
    logic [CW-1:0] ld_count_o;
    logic          ld_overflow_o;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata_o  (imem_rdata_o),
        .imem_rvalid_o (imem_rvalid_o),
        .imem_fault_o  (imem_fault_o),
        .imem_busy_o   (imem_busy_o),
        .ld_start_i    (ld_start_i),
        .ld_valid_i    (ld_valid_i),
        .ld_byte_i     (ld_byte_i),
        .ld_done_i     (ld_done_i),
        .ld_ready_o    (ld_ready_o),
        .ld_count_o    (ld_count_o),
        .ld_overflow_o (ld_overflow_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mm [DEPTH];
    logic [7:0]  q_bytes [$];
    int          exp_cnt;
    bit          exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word w of the image is bytes 4w..4w+3, little-endian, zero padded.
    task automatic model_load(input int n);
        int words;
        logic [31:0] v;
        words = (n + 3) / 4;
        for (int w = 0; w < words; w++) begin
            v = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) v[8*b +: 8] = q_bytes[4*w+b];
            mm[w % DEPTH] = v;
        end
        exp_cnt = (words > DEPTH) ? DEPTH : words;
        exp_ovf = (words >= DEPTH);
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [31:0] e;
        logic [31:0] idx;
        logic        f;
        f   = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        idx = (a / 4) % DEPTH;
        e   = f ? NOP_INSTR : mm[idx];
        @(negedge clk);
        imem_addr  = a;
        imem_rd_en = 1'b1;
        @(negedge clk);
        imem_rd_en = 1'b0;
        chk("fetch_rdata", imem_rdata_o, e);
        chk("fetch_rvalid", 32'(imem_rvalid_o), 32'd1);
        chk("fetch_fault", 32'(imem_fault_o), 32'(f));
    endtask

    task automatic run_load(input int n, input bit done_last, input bit gaps);
        @(negedge clk);
        ld_start_i = 1'b1;
        @(negedge clk);
        ld_start_i = 1'b0;
        chk("ld_cnt_start", 32'(ld_count_o), 32'd0);
        chk("ld_ready", 32'(ld_ready_o), 32'd1);
        for (int i = 0; i < n; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid_i = 1'b0;
                @(negedge clk);
            end
            ld_valid_i = 1'b1;
            ld_byte_i  = q_bytes[i];
            imem_rd_en = 1'($urandom_range(0, 1));
            imem_addr  = $urandom & 32'h0000_000C;
            ld_done_i  = done_last && (i == n - 1);
            @(negedge clk);
            chk("load_rvalid", 32'(imem_rvalid_o), 32'd0);
            chk("load_fault", 32'(imem_fault_o), 32'd0);
            if (!ld_done_i) chk("load_busy", 32'(imem_busy_o), 32'd1);
        end
        ld_valid_i = 1'b0;
        imem_rd_en = 1'b0;
        if (!done_last) begin
            ld_done_i = 1'b1;
            @(negedge clk);
        end
        ld_done_i = 1'b0;
        chk("flush_busy", 32'(imem_busy_o), 32'(n % 4 != 0));
        if (n % 4 != 0) begin
            chk("flush_ready", 32'(ld_ready_o), 32'd0);
            @(negedge clk);
            chk("post_flush_busy", 32'(imem_busy_o), 32'd0);
        end
        model_load(n);
        chk("ld_count", 32'(ld_count_o), 32'(exp_cnt));
        chk("ld_overflow", 32'(ld_overflow_o), 32'(exp_ovf));
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] w16;

        rst_i      = 1'b1;
        imem_addr  = '0;
        imem_rd_en = 1'b0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = '0;
        ld_done_i  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", imem_rdata_o, 32'h0000_0013);
        chk("rst_rvalid", 32'(imem_rvalid_o), 32'd0);
        chk("rst_fault", 32'(imem_fault_o), 32'd0);
        chk("rst_busy", 32'(imem_busy_o), 32'd0);
        chk("rst_ready", 32'(ld_ready_o), 32'd0);
        chk("rst_count", 32'(ld_count_o), 32'd0);
        chk("rst_ovf", 32'(ld_overflow_o), 32'd0);
        rst_i = 1'b0;

        q_bytes = '{8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00};
        run_load(8, 1'b0, 1'b0);
        chk("two_words", 32'(ld_count_o), 32'd2);
        fetch(32'h0);
        chk("word0_nop", imem_rdata_o, 32'h0000_0013);
        fetch(32'h4);
        chk("word1_addi", imem_rdata_o, 32'h0010_0093);

        repeat (3) begin
            @(negedge clk);
            chk("stall_rdata", imem_rdata_o, 32'h0010_0093);
            chk("stall_rvalid", 32'(imem_rvalid_o), 32'd1);
            chk("stall_fault", 32'(imem_fault_o), 32'd0);
        end

        fetch(32'h2);
        fetch(32'(DEPTH * 4));
        fetch(32'h8000_0000);
        fetch(32'h0000_0007);

        q_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(5, 1'b0, 1'b0);
        chk("flush_count", 32'(ld_count_o), 32'd2);
        fetch(32'h0);
        chk("flush_w0", imem_rdata_o, 32'hDDCC_BBAA);
        fetch(32'h4);
        chk("flush_w1", imem_rdata_o, 32'h0000_00EE);

        q_bytes.delete();
        for (int i = 0; i < 20; i++) q_bytes.push_back(8'($urandom));
        w16 = {q_bytes[19], q_bytes[18], q_bytes[17], q_bytes[16]};
        run_load(20, 1'b0, 1'b1);
        chk("ovf_flag", 32'(ld_overflow_o), 32'd1);
        chk("ovf_count", 32'(ld_count_o), 32'(DEPTH));
        fetch(32'h0);
        chk("ovf_word0", imem_rdata_o, w16);
        for (int i = 1; i < DEPTH; i++) fetch(32'(4 * i));

        repeat (25) begin
            n = $urandom_range(1, 24);
            q_bytes.delete();
            for (int i = 0; i < n; i++) q_bytes.push_back(8'($urandom));
            run_load(n, 1'($urandom_range(0, 1)), 1'b1);
            repeat (4) begin
                if ($urandom_range(0, 3) == 0) a = $urandom;
                else a = $urandom_range(0, DEPTH * 4 + 7);
                fetch(a);
            end
        end

        fetch(32'h4);
        q_bytes.delete();
        for (int i = 0; i < 6; i++) q_bytes.push_back(8'($urandom));
        @(negedge clk);
        ld_start_i = 1'b1;
        @(negedge clk);
        ld_start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid_i = 1'b1;
            ld_byte_i  = q_bytes[i];
            @(negedge clk);
        end
        ld_valid_i = 1'b0;
        chk("mid_count", 32'(ld_count_o), 32'd1);
        mm[0] = {q_bytes[3], q_bytes[2], q_bytes[1], q_bytes[0]};
        rst_i = 1'b1;
        #1;
        chk("arst_rdata", imem_rdata_o, NOP_INSTR);
        chk("arst_rvalid", 32'(imem_rvalid_o), 32'd0);
        chk("arst_busy", 32'(imem_busy_o), 32'd0);
        chk("arst_ready", 32'(ld_ready_o), 32'd0);
        chk("arst_count", 32'(ld_count_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));

        @(negedge clk);
        ld_valid_i = 1'b1;
        ld_done_i  = 1'b1;
        @(negedge clk);
        ld_valid_i = 1'b0;
        ld_done_i  = 1'b0;
        chk("idle_ignore_busy", 32'(imem_busy_o), 32'd0);
        chk("idle_ignore_cnt", 32'(ld_count_o), 32'd0);

        fetch(32'h4);
        @(negedge clk);
        ld_start_i = 1'b1;
        imem_rd_en = 1'b1;
        imem_addr  = 32'h0;
        @(negedge clk);
        ld_start_i = 1'b0;
        imem_rd_en = 1'b0;
        chk("race_busy", 32'(imem_busy_o), 32'd1);
        chk("race_rvalid", 32'(imem_rvalid_o), 32'd0);
        ld_done_i = 1'b1;
        @(negedge clk);
        ld_done_i = 1'b0;
        chk("race_idle", 32'(imem_busy_o), 32'd0);
        chk("race_count", 32'(ld_count_o), 32'd0);
        fetch(32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
